// File: rtl/interp_pkg.sv
// -----------------------------------------------------------------------------
// interp_pkg
// Shared defaults and types for the interpolation window streamer.
//   PIXEL_W : bits per integer pixel
//   BLOCK   : output block edge in pixels
//   TAPS    : subpixel filter taps
//   WIN     : window edge (BLOCK+TAPS-1)
//   IDX_W   : width of a row/column index within the window
// -----------------------------------------------------------------------------
package interp_pkg;

    localparam int PIXEL_W = 8;
    localparam int BLOCK   = 8;
    localparam int TAPS    = 8;
    localparam int WIN     = BLOCK + TAPS - 1;
    localparam int IDX_W   = $clog2(WIN);

    typedef enum logic [1:0] {
        MODE_ROWS = 2'd0,
        MODE_COLS = 2'd1,
        MODE_BOTH = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROWS = 2'd1,
        ST_COLS = 2'd2
    } state_t;

    // Encoding 3 is reserved and behaves as rows-then-columns.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd0:    return MODE_ROWS;
            2'd1:    return MODE_COLS;
            default: return MODE_BOTH;
        endcase
    endfunction

endpackage

// File: rtl/interp_window_streamer_if.sv
// -----------------------------------------------------------------------------
// interp_window_streamer_if
// Load and output handshake bundle of the window streamer.
//   load_valid/load_ready/load_data/load_mode : window offer from the fetch side
//   out_valid/out_ready                        : line handshake to the filter
//   out_data/out_idx/out_is_col/out_last       : line payload and tags
// Modports: master = fetch + filter side, slave = streamer.
// -----------------------------------------------------------------------------
interface interp_window_streamer_if #(
    parameter int PIXEL_W = interp_pkg::PIXEL_W,
    parameter int WIN     = interp_pkg::WIN,
    parameter int IDX_W   = interp_pkg::IDX_W
);
    logic                       load_valid;
    logic                       load_ready;
    logic [WIN*WIN*PIXEL_W-1:0] load_data;
    logic [1:0]                 load_mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIN*PIXEL_W-1:0]     out_data;
    logic [IDX_W-1:0]           out_idx;
    logic                       out_is_col;
    logic                       out_last;

    modport master (
        output load_valid, load_data, load_mode, out_ready,
        input  load_ready, out_valid, out_data, out_idx, out_is_col, out_last
    );

    modport slave (
        input  load_valid, load_data, load_mode, out_ready,
        output load_ready, out_valid, out_data, out_idx, out_is_col, out_last
    );
endinterface

// File: rtl/interp_window_streamer_line_select.sv
// -----------------------------------------------------------------------------
// window_line_select
// Combinational extractor of one row or column of a square pixel window.
//   window : WIN*WIN pixels, pixel(r,c) at [(r*WIN+c)*PIXEL_W +: PIXEL_W]
//   idx    : row (is_col=0) or column (is_col=1) index
//   is_col : select column instead of row
//   line   : lane i = pixel(idx,i) for rows, pixel(i,idx) for columns
// -----------------------------------------------------------------------------
module window_line_select
    import interp_pkg::*;
#(
    parameter int PIXEL_W = interp_pkg::PIXEL_W,
    parameter int WIN     = interp_pkg::WIN,
    parameter int IDX_W   = interp_pkg::IDX_W
) (
    input  logic [WIN*WIN*PIXEL_W-1:0] window,
    input  logic [IDX_W-1:0]           idx,
    input  logic                       is_col,
    output logic [WIN*PIXEL_W-1:0]     line
);

    always_comb begin
        line = '0;
        for (int unsigned i = 0; i < WIN; i++) begin
            int unsigned w_r;
            int unsigned w_c;
            w_r = is_col ? i : 32'(idx);
            w_c = is_col ? 32'(idx) : i;
            line[i*PIXEL_W +: PIXEL_W] = window[(w_r*WIN + w_c)*PIXEL_W +: PIXEL_W];
        end
    end

endmodule

// File: rtl/interp_window_streamer.sv
// -----------------------------------------------------------------------------
// interp_window_streamer
// Buffers one WIN x WIN pixel window and streams it line by line to the
// subpixel filter: rows, columns (transposed), or rows then columns.
//   clock : clock
//   reset : asynchronous, active-high reset
//   flush : synchronous abort of the current window
//   bus   : load handshake/window/mode in, line handshake/payload out
// -----------------------------------------------------------------------------
module interp_window_streamer
    import interp_pkg::*;
#(
    parameter int PIXEL_W = interp_pkg::PIXEL_W,
    parameter int BLOCK   = interp_pkg::BLOCK,
    parameter int TAPS    = interp_pkg::TAPS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    interp_window_streamer_if.slave  bus
);

    localparam int WIN   = BLOCK + TAPS - 1;
    localparam int IDX_W = $clog2(WIN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN - 1);

    state_t                     r_state, w_state_nxt;
    mode_t                      r_mode, w_mode_nxt;
    logic [IDX_W-1:0]           r_idx, w_idx_nxt;
    logic [WIN*WIN*PIXEL_W-1:0] r_window;
    logic [WIN*WIN*PIXEL_W-1:0] w_src_window;
    logic [WIN*PIXEL_W-1:0]     w_line;
    logic                       w_load;
    logic                       w_xfer;
    logic                       w_valid_nxt;
    logic                       w_is_col_nxt;
    logic                       w_last_nxt;

    logic                       r_out_valid;
    logic [WIN*PIXEL_W-1:0]     r_out_data;
    logic [IDX_W-1:0]           r_out_idx;
    logic                       r_out_is_col;
    logic                       r_out_last;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_xfer      = r_out_valid && bus.out_ready;

        case (r_state)
            ST_IDLE: begin
                if (bus.load_valid) begin
                    w_load      = 1'b1;
                    w_mode_nxt  = decode_mode(bus.load_mode);
                    w_idx_nxt   = '0;
                    w_state_nxt = (w_mode_nxt == MODE_COLS) ? ST_COLS : ST_ROWS;
                end
            end
            ST_ROWS: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (r_mode == MODE_BOTH) ? ST_COLS : ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            ST_COLS: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b0;
            w_mode_nxt  = r_mode;
            w_idx_nxt   = '0;
        end

        w_valid_nxt  = (w_state_nxt != ST_IDLE);
        w_is_col_nxt = (w_state_nxt == ST_COLS);
        w_last_nxt   = w_valid_nxt && (w_idx_nxt == LAST_IDX) &&
                       (w_is_col_nxt || (w_mode_nxt == MODE_ROWS));

        // Line 0 is registered on the load edge, before r_window holds the
        // new window, so the extractor reads the incoming data directly then.
        w_src_window = w_load ? bus.load_data : r_window;
    end

    window_line_select #(
        .PIXEL_W (PIXEL_W),
        .WIN     (WIN),
        .IDX_W   (IDX_W)
    ) u_line_select (
        .window (w_src_window),
        .idx    (w_idx_nxt),
        .is_col (w_is_col_nxt),
        .line   (w_line)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mode <= MODE_ROWS;
            r_idx  <= '0;
        end else begin
            r_mode <= w_mode_nxt;
            r_idx  <= w_idx_nxt;
        end
    end

    // Window storage carries no reset; it is only meaningful after a load.
    always_ff @(posedge clock) begin
        if (w_load) r_window <= bus.load_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_idx    <= '0;
            r_out_is_col <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            r_out_valid  <= w_valid_nxt;
            r_out_data   <= w_valid_nxt ? w_line : '0;
            r_out_idx    <= w_valid_nxt ? w_idx_nxt : '0;
            r_out_is_col <= w_is_col_nxt;
            r_out_last   <= w_last_nxt;
        end
    end

    assign bus.load_ready = (r_state == ST_IDLE);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_idx    = r_out_idx;
    assign bus.out_is_col = r_out_is_col;
    assign bus.out_last   = r_out_last;

endmodule

// File: tb/tb_interp_window_streamer.sv
// -----------------------------------------------------------------------------
// tb_interp_window_streamer
// Scoreboard bench: stimulus pushes expected lines, a negedge monitor pops and
// compares on every accepted line. Window pixel(r,c) = (r*16+c) mod 256.
// -----------------------------------------------------------------------------
module tb_interp_window_streamer;

    localparam int PW  = 8;
    localparam int WIN = 15;
    localparam int LW  = WIN * PW;

    typedef struct {
        logic [LW-1:0] data;
        logic [3:0]    idx;
        logic          is_col;
        logic          last;
    } beat_t;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    interp_window_streamer_if bus ();

    interp_window_streamer dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    valid_cycles = 0;
    logic [WIN*WIN*PW-1:0] win_img;

    task automatic check_val(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] row_line(input int k);
        logic [LW-1:0] d;
        for (int i = 0; i < WIN; i++) d[i*PW +: PW] = 8'(k*16 + i);
        return d;
    endfunction

    function automatic logic [LW-1:0] col_line(input int c);
        logic [LW-1:0] d;
        for (int i = 0; i < WIN; i++) d[i*PW +: PW] = 8'(i*16 + c);
        return d;
    endfunction

    // Push the first n expected beats of a window in the given mode (n<0: all).
    task automatic push_window(input int mode, input int n);
        beat_t b;
        int    cnt = 0;
        if (mode != 1) begin
            for (int k = 0; k < WIN; k++) begin
                b.data = row_line(k); b.idx = 4'(k); b.is_col = 1'b0;
                b.last = (mode == 0) && (k == WIN-1);
                if (n < 0 || cnt < n) exp_q.push_back(b);
                cnt++;
            end
        end
        if (mode != 0) begin
            for (int c = 0; c < WIN; c++) begin
                b.data = col_line(c); b.idx = 4'(c); b.is_col = 1'b1;
                b.last = (c == WIN-1);
                if (n < 0 || cnt < n) exp_q.push_back(b);
                cnt++;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic do_load(input int mode);
        int n = 0;
        bus.load_mode  = 2'(mode);
        bus.load_data  = win_img;
        bus.load_valid = 1'b1;
        @(negedge clock);
        while (!bus.load_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!bus.load_ready) begin
            checks++; errors++;
            $display("FAIL load_accept: load_ready stuck at 0 required 1");
        end
        @(posedge clock); #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            @(posedge clock); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Waits (posedge+1 granularity) until the presented line matches idx/is_col.
    task automatic wait_line(input string name, input int idx, input logic is_col);
        int n = 0;
        while (!(bus.out_valid && bus.out_idx == 4'(idx) && bus.out_is_col == is_col) && n < 100) begin
            n++;
            @(posedge clock); #1;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL %s_wait: line idx %0d col %0d never presented", name, idx, is_col);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        beat_t e;
        if (bus.out_valid) valid_cycles++;
        if (bus.out_valid && bus.out_ready && !flush && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got idx %0d col %0d, required no beat",
                         bus.out_idx, bus.out_is_col);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e.data || bus.out_idx !== e.idx ||
                    bus.out_is_col !== e.is_col || bus.out_last !== e.last) begin
                    errors++;
                    $display("FAIL beat: got data %h idx %0d col %0d last %0d, required data %h idx %0d col %0d last %0d",
                             bus.out_data, bus.out_idx, bus.out_is_col, bus.out_last,
                             e.data, e.idx, e.is_col, e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                win_img[(r*WIN + c)*PW +: PW] = 8'(r*16 + c);

        // Reset with a load offered: must be ignored.
        reset          = 1'b1;
        flush          = 1'b0;
        bus.out_ready  = 1'b1;
        bus.load_mode  = 2'd2;
        bus.load_data  = win_img;
        bus.load_valid = 1'b1;
        repeat (3) @(negedge clock);
        check_val("rst_out_valid",  LW'(bus.out_valid),  LW'(0));
        check_val("rst_out_data",   bus.out_data,        '0);
        check_val("rst_load_ready", LW'(bus.load_ready), LW'(1));
        check_val("rst_out_idx",    LW'(bus.out_idx),    LW'(0));
        check_val("rst_flags",      LW'({bus.out_is_col, bus.out_last}), LW'(0));
        @(posedge clock); #1;
        bus.load_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_val("post_rst_idle", LW'(bus.out_valid), LW'(0));

        // Mode 2, no backpressure: 30 beats back to back.
        @(posedge clock); #1;
        push_window(2, -1);
        valid_cycles = 0;
        do_load(2);
        wait_drain("mode2");
        check_val("mode2_ready_after", LW'(bus.load_ready), LW'(1));
        check_val("mode2_valid_after", LW'(bus.out_valid),  LW'(0));
        check_val("mode2_valid_cycles", LW'(valid_cycles),  LW'(30));

        // Backpressure on row 4, mode 0.
        push_window(0, -1);
        do_load(0);
        wait_line("bp", 4, 1'b0);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            check_val("bp_hold_lane0", LW'(bus.out_data[7:0]), LW'(8'h40));
            check_val("bp_hold_idx",   LW'(bus.out_idx),       LW'(4));
            check_val("bp_hold_valid", LW'(bus.out_valid),     LW'(1));
        end
        @(posedge clock); #1;
        bus.out_ready = 1'b1;
        wait_drain("bp");

        // Mode 1 then mode 3.
        push_window(1, -1);
        do_load(1);
        check_val("mode1_first_col", LW'({bus.out_is_col, bus.out_idx}), LW'({1'b1, 4'd0}));
        check_val("mode1_first_data", bus.out_data, col_line(0));
        wait_drain("mode1");
        push_window(3, -1);
        do_load(3);
        wait_drain("mode3");

        // Flush on the cycle row 7 would transfer.
        push_window(2, 7);
        do_load(2);
        wait_line("flush", 7, 1'b0);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check_val("flush_valid", LW'(bus.out_valid),  LW'(0));
        check_val("flush_ready", LW'(bus.load_ready), LW'(1));
        check_val("flush_data",  bus.out_data,        '0);
        check_val("flush_queue", LW'(exp_q.size()),   LW'(0));
        push_window(0, -1);
        do_load(0);
        check_val("flush_restart_idx", LW'({bus.out_is_col, bus.out_idx}), LW'(0));
        wait_drain("flush_reload");

        // Asynchronous reset during column 3.
        push_window(2, 18);
        do_load(2);
        wait_line("areset", 3, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_val("areset_valid", LW'(bus.out_valid),  LW'(0));
        check_val("areset_ready", LW'(bus.load_ready), LW'(1));
        check_val("areset_data",  bus.out_data,        '0);
        check_val("areset_flags", LW'({bus.out_is_col, bus.out_last, bus.out_idx}), LW'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        check_val("areset_queue", LW'(exp_q.size()), LW'(0));
        @(negedge clock);
        check_val("areset_no_resume", LW'(bus.out_valid), LW'(0));
        @(posedge clock); #1;
        push_window(0, -1);
        do_load(0);
        wait_drain("areset_reload");

        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interp_window_streamer.md
# interp_window_streamer

Buffers one (BLOCK+TAPS-1)² window of integer pixels and streams it, one line per handshake, to the 8-tap subpixel filter. It emits rows first, then columns (transposed), or only one of the two, depending on a per-window mode. It is a parametrised successor of the fixed 15×15 row/column input mux. It sits between the reference-pixel fetch and the horizontal/vertical filter array, and adds valid/ready flow control, mode selection and flush.

## Interface
- PIXEL_W, 8, bits per integer pixel
- BLOCK, 8, output block edge (pixels)
- TAPS, 8, filter taps; derived localparam WIN = BLOCK+TAPS-1 (15 by default), IDX_W = $clog2(WIN)
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- load_valid  in  1  window offered
- load_ready  out  1  block can accept a window
- load_data  in  WIN*WIN*PIXEL_W  window; pixel(r,c) = load_data[(r*WIN+c)*PIXEL_W +: PIXEL_W]
- load_mode  in  2  0 rows only, 1 cols only, 2 rows then cols, 3 treated as 2
- flush  in  1  synchronous abort of the current window
- out_valid  out  1  out_data holds a valid line
- out_ready  in  1  consumer accepts line
- out_data  out  WIN*PIXEL_W  line; lane i = out_data[i*PIXEL_W +: PIXEL_W]
- out_idx  out  IDX_W  row or column index of current line
- out_is_col  out  1  current line is a column
- out_last  out  1  final line of this window

## Operation
- FSM states: IDLE, ROWS, COLS. load_ready = (state==IDLE).
- IDLE: when load_valid is high, capture load_data into the window register and latch the mode. Go to ROWS (modes 0/2/3) or COLS (mode 1) with idx=0.
- Row line r: lane i = pixel(r,i). Column line c: lane i = pixel(i,c). Lane 0 is at the LSBs.
- out_valid = 1 in ROWS/COLS. A transfer happens when out_valid && out_ready.
- On a transfer in ROWS: if idx<WIN-1, idx++. If idx==WIN-1, go to COLS with idx=0 when mode is 2/3, else go to IDLE.
- On a transfer in COLS: idx++ until WIN-1, then go to IDLE.
- out_last = 1 on row WIN-1 in mode 0, and on column WIN-1 in modes 1/2/3. It is 0 otherwise.
- flush: next state IDLE, out_valid=0, out_data/out_idx/out_is_col/out_last=0. flush overrides a simultaneous transfer and a simultaneous load.
- While stalled (out_valid && !out_ready), out_data, out_idx, out_is_col and out_last hold stable.
- The window register has no reset. Its contents are undefined until the first load.

## Timing
- All outputs are registered except load_ready, which is decoded from the state register.
- Reset values: state IDLE, load_ready 1, out_valid 0, out_data 0, out_idx 0, out_is_col 0, out_last 0.
- Load accepted at edge T → line 0 valid after T (visible in cycle T+1).
- Each transfer at edge T presents the next line in cycle T+1. Throughput is one line per cycle with out_ready held high.
- Final transfer at edge T → IDLE in cycle T+1 with load_ready=1. The next window is accepted at the earliest at edge T+1, giving one bubble cycle per window.
- Mode 2 with no backpressure: 2*WIN cycles of out_valid per window. Modes 0/1: WIN cycles.
- Reset asserted mid-stream: outputs go to reset values immediately. No partial window resumes after reset deasserts.

## Structure
- Shared package interp_pkg: PIXEL_W, BLOCK, TAPS, WIN, IDX_W defaults; mode enum (MODE_ROWS, MODE_COLS, MODE_BOTH); state enum.
- Sub-module window_line_select: combinational extractor, with inputs window, idx and is_col, and output line. The top contains the FSM, window register and output registers.

## Test plan
All scenarios use the defaults (WIN=15) and load pixel(r,c) = (r*16+c) mod 256.
- Reset: reset asserted → out_valid 0, out_data 0, load_ready 1. Loads are ignored until reset is released.
- Mode 2, out_ready always 1 → 30 beats. Beat k<15: idx k, is_col 0, lane i = k*16+i. Beat 15+c: is_col 1, lane i = i*16+c. out_last only on beat 29. load_ready 1 in the following cycle.
- Backpressure: out_ready low for 3 cycles while row 4 is presented → out_data (lane 0 = 0x40) and idx 4 hold for all 3 cycles. Row 5 follows the cycle after out_ready rises. No beat is lost or duplicated.
- Mode 1 → 15 beats, first beat is_col 1, idx 0, lane i = i*16. out_last on idx 14. Mode 3 behaves exactly like mode 2.
- Flush on the cycle row 7 transfers → next cycle out_valid 0, load_ready 1. A new window loaded afterwards streams from row 0.
- Asynchronous reset pulse during column 3 → out_valid drops without a clock edge. After release, state is IDLE and the next load restarts at row 0.
